// File: rtl/uart_rfifo_ctrl_pkg.sv
// uart_rfifo_ctrl_pkg: shared receive FIFO geometry and entry layout
package uart_rfifo_ctrl_pkg;
  localparam int FIFO_WIDTH = 11;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_POINTER_W = 4;
  localparam int FIFO_COUNTER_W = 5;
  typedef logic [2:0] err_t;
endpackage

// File: rtl/uart_rfifo_ctrl_raminfr.sv
// raminfr: dual-port RAM, synchronous write at top, asynchronous read at bottom
module raminfr #(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int depth = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] top,
  input  logic [addr_width-1:0] bottom,
  input  logic [data_width-1:0] di,
  output logic [data_width-1:0] dpo
);
  logic [data_width-1:0] ram [depth];
  always_ff @(posedge clk)
    if (we) ram[top] <= di;
  assign dpo = ram[bottom];
endmodule

// File: rtl/uart_rfifo_ctrl.sv
// uart_rfifo_ctrl: UART receive FIFO with per-entry error flops, overrun and fill count
module uart_rfifo_ctrl
  import uart_rfifo_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [FIFO_WIDTH-1:0]     data_in,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      fifo_reset,
  input  logic                      reset_status,
  output logic [FIFO_WIDTH-1:0]     data_out,
  output logic                      overrun,
  output logic [FIFO_COUNTER_W-1:0] count,
  output logic                      error_bit
);
  logic [FIFO_POINTER_W-1:0] top, bottom;
  err_t err [FIFO_DEPTH];
  logic [7:0] ram_out;
  logic full, empty, wr, rd;
  assign full = count == FIFO_COUNTER_W'(FIFO_DEPTH);
  assign empty = count == '0;
  assign wr = !fifo_reset & push & (pop | !full);
  assign rd = !fifo_reset & pop & !empty;
  raminfr #(.data_width(8), .addr_width(FIFO_POINTER_W), .depth(FIFO_DEPTH)) u_ram (
    .clk(clk), .we(wr), .top(top), .bottom(bottom), .di(data_in[10:3]), .dpo(ram_out)
  );
  always_ff @(posedge clk or posedge wb_rst_i)
    if (wb_rst_i) begin
      top <= '0;
      bottom <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else if (fifo_reset) begin
      top <= '0;
      bottom <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr) top <= top + 1'b1;
      if (rd) bottom <= bottom + 1'b1;
      count <= count + FIFO_COUNTER_W'(wr & !rd) - FIFO_COUNTER_W'(rd & !wr);
      overrun <= (push & !pop & full) | (overrun & !reset_status);
    end
  // when full with push&pop, top==bottom: the write must override the clear
  always_ff @(posedge clk or posedge wb_rst_i)
    if (wb_rst_i || fifo_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) err[i] <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (rd && bottom == FIFO_POINTER_W'(i)) err[i] <= '0;
        if (wr && top == FIFO_POINTER_W'(i)) err[i] <= data_in[2:0];
      end
    end
  always_comb begin
    error_bit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) error_bit = error_bit | (|err[i]);
  end
  assign data_out = {ram_out, empty ? 3'b000 : err[bottom]};
endmodule

// File: tb/tb_uart_rfifo_ctrl.sv
// tb_uart_rfifo_ctrl: queue-model checking of the receive FIFO under directed and random traffic
module tb_uart_rfifo_ctrl;
  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  logic [10:0] data_in = '0;
  logic push = 1'b0, pop = 1'b0, fifo_reset = 1'b0, reset_status = 1'b0;
  logic [10:0] data_out;
  logic overrun, error_bit;
  logic [4:0] count;
  int checks = 0, errors = 0;
  logic [10:0] q[$];
  logic m_ovr = 1'b0;
  logic [7:0] last;

  uart_rfifo_ctrl dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .data_in(data_in), .push(push), .pop(pop),
    .fifo_reset(fifo_reset), .reset_status(reset_status), .data_out(data_out),
    .overrun(overrun), .count(count), .error_bit(error_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk or posedge wb_rst_i)
    if (wb_rst_i) begin
      q.delete();
      m_ovr = 1'b0;
    end else if (fifo_reset) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      if (push && !pop && q.size() == 16) m_ovr = 1'b1;
      else if (reset_status) m_ovr = 1'b0;
      if (push && pop && q.size() != 0) begin
        void'(q.pop_front());
        q.push_back(data_in);
      end else if (push && !pop && q.size() < 16) q.push_back(data_in);
      else if (pop && !push && q.size() != 0) void'(q.pop_front());
      else if (push && pop) q.push_back(data_in);
    end

  always @(negedge clk) begin
    logic e;
    e = 1'b0;
    foreach (q[i]) e = e | (|q[i][2:0]);
    chk("count", 32'(count), 32'(q.size()));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("error_bit", 32'(error_bit), 32'(e));
    chk("head_err", 32'(data_out[2:0]), q.size() != 0 ? 32'(q[0][2:0]) : 0);
    if (q.size() != 0) chk("head_data", 32'(data_out[10:3]), 32'(q[0][10:3]));
  end

  task automatic step(input logic pu, input logic po, input logic fr, input logic rs, input logic [10:0] d);
    push = pu; pop = po; fifo_reset = fr; reset_status = rs; data_in = d;
    @(posedge clk);
    #1;
    push = 0; pop = 0; fifo_reset = 0; reset_status = 0;
  endtask

  task automatic pushb(input logic [7:0] b, input logic [2:0] e);
    step(1, 0, 0, 0, {b, e});
  endtask

  task automatic popb();
    step(0, 1, 0, 0, '0);
  endtask

  initial begin
    #12 wb_rst_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_error_bit", 32'(error_bit), 0);
    chk("rst_head_err", 32'(data_out[2:0]), 0);
    pushb(8'h41, 0); pushb(8'h42, 0); pushb(8'h43, 0);
    chk("three_count", 32'(count), 3);
    chk("three_head", 32'(data_out), 32'h208);
    for (int i = 0; i < 3; i++) begin
      chk("pop_order", 32'(data_out[10:3]), 32'h41 + i);
      popb();
    end
    chk("drained_count", 32'(count), 0);
    for (int i = 1; i <= 16; i++) pushb(8'(i), 0);
    pushb(8'hFF, 0);
    chk("full_count", 32'(count), 16);
    chk("full_overrun", 32'(overrun), 1);
    chk("full_head", 32'(data_out[10:3]), 1);
    step(0, 0, 0, 1, '0);
    chk("status_clear", 32'(overrun), 0);
    step(1, 1, 0, 0, {8'h55, 3'b000});
    chk("pp_full_count", 32'(count), 16);
    chk("pp_full_overrun", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) begin
      last = data_out[10:3];
      popb();
    end
    chk("pp_full_last", 32'(last), 32'h55);
    pushb(8'h10, 3'b010); pushb(8'h11, 0); pushb(8'h12, 0);
    chk("err_set", 32'(error_bit), 1);
    popb();
    chk("err_clear", 32'(error_bit), 0);
    popb(); popb();
    for (int i = 0; i < 5; i++) pushb(8'(8'hA0 + i), 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, {8'(8'hB0 + i), 3'(i)});
    chk("wrap_count", 32'(count), 5);
    chk("wrap_head", 32'(data_out[10:3]), 32'hBF);
    for (int i = 0; i < 11; i++) pushb(8'(i), 3'b001);
    pushb(8'h77, 0);
    chk("pre_flush_overrun", 32'(overrun), 1);
    step(1, 0, 1, 0, {8'h99, 3'b111});
    chk("flush_count", 32'(count), 0);
    chk("flush_error_bit", 32'(error_bit), 0);
    chk("flush_overrun", 32'(overrun), 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 5, 11'($urandom));
    for (int i = 0; i < 17; i++) pushb(8'(i), 3'b100);
    #1 wb_rst_i = 1'b1;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_overrun", 32'(overrun), 0);
    chk("async_error_bit", 32'(error_bit), 0);
    #1 wb_rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
